axi_sram_write_slave: RTL

- AXI slave-side write endpoint; the far end of the interconnect write-data path, sitting in front of one SRAM.
- Accepts one AW burst at a time, sinks its W beats into the SRAM write port, then returns a single B response.
- Instantiated per memory slave (IM/DM) behind the interconnect's AW/W/B routing.

---
 rtl/axi_sram_write_slave.sv | 129 ++++++++++++
 1 files changed

// File: rtl/axi_sram_write_slave.sv
// AXI write endpoint in front of a single SRAM: one AW burst at a time, W beats go straight
// to the SRAM write port, then a single B response.
module axi_sram_write_slave #(
    parameter int unsigned ID_BITS       = 8,
    parameter int unsigned ADDR_BITS     = 32,
    parameter int unsigned DATA_BITS     = 32,
    parameter int unsigned STRB_BITS     = 4,
    parameter int unsigned LEN_BITS      = 4,
    parameter int unsigned MEM_ADDR_BITS = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ID_BITS-1:0]       AWID_S,
    input  logic [ADDR_BITS-1:0]     AWADDR_S,
    input  logic [LEN_BITS-1:0]      AWLEN_S,
    input  logic [2:0]               AWSIZE_S,
    input  logic [1:0]               AWBURST_S,
    input  logic                     AWVALID_S,
    output logic                     AWREADY_S,
    input  logic [DATA_BITS-1:0]     WDATA_S,
    input  logic [STRB_BITS-1:0]     WSTRB_S,
    input  logic                     WLAST_S,
    input  logic                     WVALID_S,
    output logic                     WREADY_S,
    output logic [ID_BITS-1:0]       BID_S,
    output logic [1:0]               BRESP_S,
    output logic                     BVALID_S,
    input  logic                     BREADY_S,
    output logic                     CS,
    output logic [STRB_BITS-1:0]     WEB,
    output logic [MEM_ADDR_BITS-1:0] A,
    output logic [DATA_BITS-1:0]     DI
);
    // Byte address kept only as wide as the SRAM so INCR wraps modulo the memory size.
    localparam int unsigned BYTE_ADDR_BITS = MEM_ADDR_BITS + 2;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                    state;
    logic [BYTE_ADDR_BITS-1:0] addr;
    logic [LEN_BITS-1:0]       cnt;
    logic [LEN_BITS-1:0]       len;
    logic [ID_BITS-1:0]        id;
    logic [1:0]                burst;
    logic                      err;
    logic                      aw_rdy;
    logic                      w_rdy;
    logic                      b_vld;

    logic w_hs;
    logic last_cnt;
    logic aw_err;
    logic unused_addr;

    assign unused_addr = ^AWADDR_S[ADDR_BITS-1:BYTE_ADDR_BITS];

    assign w_hs     = WVALID_S & w_rdy;
    assign last_cnt = (cnt == len);
    assign aw_err   = (AWSIZE_S != 3'b010) || AWBURST_S[1] || (AWADDR_S[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr   <= '0;
            cnt    <= '0;
            len    <= '0;
            id     <= '0;
            burst  <= '0;
            err    <= 1'b0;
            aw_rdy <= 1'b1;
            w_rdy  <= 1'b0;
            b_vld  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (AWVALID_S) begin
                        id     <= AWID_S;
                        addr   <= AWADDR_S[BYTE_ADDR_BITS-1:0];
                        len    <= AWLEN_S;
                        burst  <= AWBURST_S;
                        cnt    <= '0;
                        err    <= aw_err;
                        aw_rdy <= 1'b0;
                        w_rdy  <= 1'b1;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        if (burst == 2'b01) begin
                            addr <= addr + BYTE_ADDR_BITS'(4);
                        end
                        cnt <= cnt + LEN_BITS'(1);
                        // Either WLAST or the beat count closes the burst; disagreement is an error.
                        if (WLAST_S || last_cnt) begin
                            if (WLAST_S != last_cnt) begin
                                err <= 1'b1;
                            end
                            w_rdy <= 1'b0;
                            b_vld <= 1'b1;
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (BREADY_S) begin
                        b_vld  <= 1'b0;
                        aw_rdy <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign AWREADY_S = aw_rdy;
    assign WREADY_S  = w_rdy;
    assign BVALID_S  = b_vld;
    assign BID_S     = id;
    assign BRESP_S   = (b_vld && err) ? 2'b10 : 2'b00;

    // Errored bursts still consume beats and strobe CS, but write no bytes.
    assign CS  = w_hs;
    assign WEB = (w_hs && !err) ? ~WSTRB_S : '1;
    assign A   = w_hs ? addr[BYTE_ADDR_BITS-1:2] : '0;
    assign DI  = w_hs ? WDATA_S : '0;

endmodule
